// File: rtl/anim_pkg.sv
// Shared state encoding, colours and screen geometry for the sprite animator and VGA adapter.
package anim_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_MOVE,
    S_DRAW
  } anim_state_t;

  localparam logic [2:0] FG_DEFAULT = 3'b110;
  localparam logic [2:0] BG_DEFAULT = 3'b000;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
endpackage

// File: rtl/sprite_anim_ctrl_pixel_scan.sv
// 2-D px/py scan over a SIZE x SIZE square, px fastest; wraps to 0 after the last pixel.
module pixel_scan #(
  parameter int SIZE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  output logic [3:0] px,
  output logic [3:0] py,
  output logic       done
);
  localparam logic [3:0] LAST = 4'(SIZE - 1);

  assign done = run && (px == LAST) && (py == LAST);

  // Counter returns to 0 on the last pixel, so every pass starts clean.
  always_ff @(posedge clock) begin
    if (!reset) begin
      px <= '0;
      py <= '0;
    end else if (run) begin
      if (px == LAST) begin
        px <= '0;
        py <= (py == LAST) ? 4'd0 : py + 4'd1;
      end else begin
        px <= px + 4'd1;
      end
    end
  end
endmodule

// File: rtl/sprite_anim_ctrl.sv
// Falling-square sequencer: wait for frame tick, erase, step Y, redraw; one pixel write per clock.
module sprite_anim_ctrl
  import anim_pkg::*;
#(
  parameter int         SIZE      = 4,
  parameter int         STEP      = 1,
  parameter int         Y_LIMIT   = SCREEN_H,
  parameter logic [2:0] FG_COLOUR = FG_DEFAULT,
  parameter logic [2:0] BG_COLOUR = BG_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       halt,
  input  logic [7:0] start_x,
  input  logic       frame_tick,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       wrapped,
  output logic       tick_drop
);
  anim_state_t state, next;
  logic [7:0]  pos_x;
  logic [6:0]  pos_y;
  logic        pending;
  logic [3:0]  px, py;
  logic        scan_run, scan_done;
  logic [7:0]  y_adv;

  assign scan_run = (state == S_ERASE) || (state == S_DRAW);
  assign busy     = (state != S_IDLE);
  assign y_adv    = {1'b0, pos_y} + 8'(STEP);

  pixel_scan #(.SIZE(SIZE)) u_scan (
    .clock(clock),
    .reset(reset),
    .run  (scan_run),
    .px   (px),
    .py   (py),
    .done (scan_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:  if (go) next = S_DRAW;
      S_WAIT: begin
        if (halt)                         next = S_IDLE;
        else if (pending || frame_tick)   next = S_ERASE;
      end
      S_ERASE: if (scan_done) next = S_MOVE;
      S_MOVE:  next = S_DRAW;
      S_DRAW:  if (scan_done) next = S_WAIT;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pos_x      <= '0;
      pos_y      <= '0;
      pending    <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      wrapped    <= 1'b0;
      tick_drop  <= 1'b0;
    end else begin
      wrapped   <= 1'b0;
      tick_drop <= 1'b0;
      vga_plot  <= scan_run;

      if (state == S_IDLE && go) begin
        pos_x <= start_x;
        pos_y <= '0;
      end

      if (state == S_MOVE) begin
        if (y_adv + 8'(SIZE) > 8'(Y_LIMIT)) begin
          pos_y   <= '0;
          wrapped <= 1'b1;
        end else begin
          pos_y <= y_adv[6:0];
        end
      end

      // A tick arriving alongside a pending-triggered erase becomes the new pending tick.
      if (state == S_WAIT && next == S_ERASE) begin
        pending <= pending & frame_tick;
      end else if (frame_tick && state != S_WAIT && !(state == S_IDLE && go)) begin
        if (pending) tick_drop <= 1'b1;
        pending <= 1'b1;
      end

      if (scan_run) begin
        vga_x      <= pos_x + {4'b0, px};
        vga_y      <= pos_y + {3'b0, py};
        vga_colour <= (state == S_ERASE) ? BG_COLOUR : FG_COLOUR;
      end
    end
  end
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl: draw, erase/move, wrap, dropped ticks, halt and reset.
module tb_sprite_anim_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       go, halt, frame_tick;
  logic [7:0] start_x;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, wrapped, tick_drop;

  int checks = 0;
  int passed = 0;
  logic [7:0] cur_x;

  localparam logic [2:0] FG = 3'b110;
  localparam logic [2:0] BG = 3'b000;

  sprite_anim_ctrl dut (
    .clock(clock), .reset(reset), .go(go), .halt(halt), .start_x(start_x),
    .frame_tick(frame_tick), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .wrapped(wrapped), .tick_drop(tick_drop)
  );

  always #5 clock = ~clock;

  task automatic test_reset;
    reset = 1'b0; go = 1'b0; halt = 1'b0; frame_tick = 1'b0; start_x = 8'd0;
    repeat (3) @(negedge clock);
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour, busy, wrapped, tick_drop} !== 22'd0)
      $display("FAIL reset_outputs: got plot=%b x=%0d y=%0d col=%b busy=%b wr=%b td=%b, want all 0",
               vga_plot, vga_x, vga_y, vga_colour, busy, wrapped, tick_drop);
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
    else passed++;
  endtask

  // go with a simultaneous tick: the tick must be ignored, so WAIT holds after the draw.
  task automatic test_draw;
    logic [18:0] exp, obs;
    cur_x = 8'd40;
    start_x = cur_x; go = 1'b1; frame_tick = 1'b1;
    @(negedge clock);
    go = 1'b0; frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || vga_plot !== 1'b0)
      $display("FAIL draw_entry: busy=%b plot=%b want busy=1 plot=0", busy, vga_plot);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      exp = {1'b1, cur_x + 8'(i % 4), 7'(i / 4), FG};
      obs = {vga_plot, vga_x, vga_y, vga_colour};
      checks++;
      if (obs !== exp) $display("FAIL draw_pixel%0d: got %h want %h", i, obs, exp);
      else passed++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (vga_plot !== 1'b0 || busy !== 1'b1 || tick_drop !== 1'b0)
        $display("FAIL draw_wait%0d: plot=%b busy=%b td=%b want 0/1/0", i, vga_plot, busy, tick_drop);
      else passed++;
    end
  endtask

  task automatic run_frame(input logic [6:0] y0, input logic [6:0] y1, input int wrap_exp);
    logic [18:0] exp, obs;
    int wraps = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clock);
      if (c == 1) frame_tick = 1'b0;
      if (wrapped === 1'b1) wraps++;
      obs = {vga_plot, vga_x, vga_y, vga_colour};
      if (c >= 2 && c <= 17)
        exp = {1'b1, cur_x + 8'((c - 2) % 4), y0 + 7'((c - 2) / 4), BG};
      else if (c >= 19 && c <= 34)
        exp = {1'b1, cur_x + 8'((c - 19) % 4), y1 + 7'((c - 19) / 4), FG};
      else
        exp = {1'b0, obs[17:0]};
      checks++;
      if (obs !== exp) $display("FAIL frame_y%0d_c%0d: got %h want %h", y0, c, obs, exp);
      else passed++;
    end
    checks++;
    if (wraps !== wrap_exp || busy !== 1'b1)
      $display("FAIL frame_y%0d_wrap: wraps=%0d busy=%b want %0d/1", y0, wraps, busy, wrap_exp);
    else passed++;
  endtask

  task automatic test_frame;
    run_frame(7'd0, 7'd1, 0);
  endtask

  task automatic test_wrap;
    for (int y = 1; y < 116; y++) run_frame(7'(y), 7'(y + 1), 0);
    run_frame(7'd116, 7'd0, 1);
  endtask

  // Ticks at c=3 (sets pending) and c=6 (dropped); second ERASE follows one WAIT cycle after DRAW.
  task automatic test_tick_drop;
    int drops = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clock);
      if (tick_drop === 1'b1) drops++;
      if (c == 7) begin
        checks++;
        if (tick_drop !== 1'b1) $display("FAIL drop_pulse: tick_drop=%b want 1", tick_drop);
        else passed++;
      end
      if (c == 8) begin
        checks++;
        if (tick_drop !== 1'b0) $display("FAIL drop_width: tick_drop=%b want 0", tick_drop);
        else passed++;
      end
      if (c == 35) begin
        checks++;
        if (vga_plot !== 1'b0) $display("FAIL drop_gap: plot=%b want 0", vga_plot);
        else passed++;
      end
      if (c == 36) begin
        checks++;
        if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, cur_x, 7'd1, BG})
          $display("FAIL drop_reerase: got plot=%b x=%0d y=%0d col=%b want 1/%0d/1/000",
                   vga_plot, vga_x, vga_y, vga_colour, cur_x);
        else passed++;
      end
      frame_tick = (c == 3 || c == 6);
    end
    checks++;
    if (drops !== 1) $display("FAIL drop_count: got %0d want 1", drops);
    else passed++;
  endtask

  // Erase at y=2, draw at y=3; halt raised mid-DRAW.
  task automatic test_halt;
    int fg_plots = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 1) frame_tick = 1'b0;
      if (vga_plot === 1'b1 && vga_colour === FG) fg_plots++;
      if (c == 34) begin
        checks++;
        if (busy !== 1'b1 || vga_y !== 7'd6) $display("FAIL halt_last: busy=%b y=%0d want 1/6", busy, vga_y);
        else passed++;
      end
      if (c == 35) begin
        checks++;
        if (busy !== 1'b0) $display("FAIL halt_idle: busy=%b want 0", busy);
        else passed++;
      end
      if (c == 20) halt = 1'b1;
    end
    halt = 1'b0;
    checks++;
    if (fg_plots !== 16) $display("FAIL halt_plots: got %0d want 16", fg_plots);
    else passed++;
  endtask

  // start_x=254 shows 8-bit x wrap, then reset lands in cycle 5 of the DRAW pass.
  task automatic test_reset_mid_draw;
    logic [7:0] xs [4];
    xs[0] = 8'd254; xs[1] = 8'd255; xs[2] = 8'd0; xs[3] = 8'd1;
    start_x = 8'd254; go = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) go = 1'b0;
      if (c >= 2 && c <= 5) begin
        checks++;
        if ({vga_plot, vga_x, vga_y} !== {1'b1, xs[c - 2], 7'd0})
          $display("FAIL xwrap_pixel%0d: plot=%b x=%0d y=%0d want 1/%0d/0", c - 2, vga_plot, vga_x, vga_y, xs[c - 2]);
        else passed++;
      end
      if (c >= 6) begin
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0)
          $display("FAIL midreset_c%0d: plot=%b busy=%b want 0/0", c, vga_plot, busy);
        else passed++;
      end
      if (c == 5) reset = 1'b0;
      if (c == 6) reset = 1'b1;
    end
  endtask

  initial begin
    test_reset;
    test_draw;
    test_frame;
    test_wrap;
    test_tick_drop;
    test_halt;
    test_reset_mid_draw;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
